// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetch/decode/execute/write-back/PC-update sequencing with a req/ack fetch handshake.
// Optional macro CONT_CICLOS_EN adds saturating cycle and instruction counters (ciclos, instrucoes).
module controle_multiciclo #(
    parameter int unsigned LARG_OP   = 4,
    parameter int unsigned OP_SALTO  = 11,
    parameter int unsigned OP_DESVIO = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LARG_OP-1:0] opcode,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               EscIR,
    output logic               EscCP,
    output logic               EscCondCP,
    output logic               EscReg,
    output logic               ULA_A,
    output logic [1:0]         ULA_B,
    output logic [3:0]         ULA_OP,
    output logic [1:0]         FonteCP,
    output logic               flagimm,
    output logic               ilegal,
    output logic               instr_fim,
    output logic [2:0]         estado
`ifdef CONT_CICLOS_EN
    ,
    output logic [15:0]        ciclos,
    output logic [15:0]        instrucoes
`endif
);

    typedef enum logic [2:0] {
        INICIO  = 3'd0,
        BUSCA   = 3'd1,
        DECOD   = 3'd2,
        EXEC    = 3'd3,
        ESCRITA = 3'd4,
        SALTO   = 3'd5,
        DESVIO  = 3'd6
    } estado_t;

    estado_t            st;
    logic [LARG_OP-1:0] op_r;

    function automatic logic classe_reg(input logic [LARG_OP-1:0] op);
        return op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5};
    endfunction

    function automatic logic classe_imm(input logic [LARG_OP-1:0] op);
        return (op == 4'd2) || (op inside {[4'd6:4'd10]});
    endfunction

    // State register and latched opcode; unused encodings recover to BUSCA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= INICIO;
            op_r <= '0;
        end else begin
            case (st)
                INICIO: st <= BUSCA;
                BUSCA:  if (mem_ack) st <= DECOD;
                DECOD: begin
                    op_r <= opcode;
                    if (classe_reg(opcode) || classe_imm(opcode))
                        st <= EXEC;
                    else if (opcode == LARG_OP'(OP_SALTO))
                        st <= SALTO;
                    else if (opcode == LARG_OP'(OP_DESVIO))
                        st <= DESVIO;
                    else
                        st <= BUSCA;
                end
                EXEC:    st <= ESCRITA;
                ESCRITA: st <= BUSCA;
                SALTO:   st <= BUSCA;
                DESVIO:  st <= BUSCA;
                default: st <= BUSCA;
            endcase
        end
    end

    // Strobes follow the state register so reset clears them without waiting for a clock.
    always_comb begin
        mem_req   = 1'b0;
        EscIR     = 1'b0;
        EscCP     = 1'b0;
        EscCondCP = 1'b0;
        EscReg    = 1'b0;
        ULA_A     = 1'b0;
        ULA_B     = 2'b00;
        ULA_OP    = 4'd0;
        FonteCP   = 2'b00;
        flagimm   = 1'b0;
        ilegal    = 1'b0;
        instr_fim = 1'b0;
        case (st)
            BUSCA: begin
                mem_req = 1'b1;
                ULA_B   = 2'b01;
                EscIR   = mem_ack;
                EscCP   = mem_ack;
            end
            DECOD: begin
                if (!(classe_reg(opcode) || classe_imm(opcode) ||
                      opcode == LARG_OP'(OP_SALTO) || opcode == LARG_OP'(OP_DESVIO))) begin
                    ilegal    = 1'b1;
                    instr_fim = 1'b1;
                end
            end
            EXEC, ESCRITA: begin
                ULA_A   = 1'b1;
                ULA_OP  = 4'(op_r);
                ULA_B   = classe_imm(op_r) ? 2'b10 : 2'b00;
                flagimm = classe_imm(op_r);
                if (st == ESCRITA) begin
                    EscReg    = 1'b1;
                    instr_fim = 1'b1;
                end
            end
            SALTO: begin
                EscCP     = 1'b1;
                FonteCP   = 2'b10;
                instr_fim = 1'b1;
            end
            DESVIO: begin
                EscCondCP = 1'b1;
                ULA_A     = 1'b1;
                ULA_OP    = 4'(op_r);
                FonteCP   = 2'b01;
                instr_fim = 1'b1;
            end
            default: ;
        endcase
    end

    assign estado = st;

`ifdef CONT_CICLOS_EN
    // Saturating activity counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ciclos     <= 16'd0;
            instrucoes <= 16'd0;
        end else begin
            if (st != INICIO && ciclos != 16'hFFFF)
                ciclos <= ciclos + 16'd1;
            if (instr_fim && instrucoes != 16'hFFFF)
                instrucoes <= instrucoes + 16'd1;
        end
    end
`else
    // Counters not built.
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: per-instruction expected cycle traces built from the phase rules.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       mem_ack;
    logic       mem_req, EscIR, EscCP, EscCondCP, EscReg, ULA_A, flagimm, ilegal, instr_fim;
    logic [1:0] ULA_B, FonteCP;
    logic [3:0] ULA_OP;
    logic [2:0] estado;
`ifdef CONT_CICLOS_EN
    logic [15:0] ciclos, instrucoes;
`endif

    controle_multiciclo dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ack(mem_ack),
        .mem_req(mem_req), .EscIR(EscIR), .EscCP(EscCP), .EscCondCP(EscCondCP),
        .EscReg(EscReg), .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_OP(ULA_OP),
        .FonteCP(FonteCP), .flagimm(flagimm), .ilegal(ilegal),
        .instr_fim(instr_fim), .estado(estado)
`ifdef CONT_CICLOS_EN
        , .ciclos(ciclos), .instrucoes(instrucoes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ack;
        logic [3:0]  op;
        logic [2:0]  st;
        logic [16:0] outs;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle    = 0;
    int   m_ciclos = 0;
    int   m_instr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic req, ir, cp, ccp, rg, a,
                                       input logic [1:0] b, input logic [3:0] aop,
                                       input logic [1:0] fonte, input logic imm, il, fim);
        return {req, ir, cp, ccp, rg, a, b, aop, fonte, imm, il, fim};
    endfunction

    function automatic logic [16:0] dut_outs();
        return {mem_req, EscIR, EscCP, EscCondCP, EscReg, ULA_A, ULA_B, ULA_OP,
                FonteCP, flagimm, ilegal, instr_fim};
    endfunction

    function automatic cyc_t ent(input logic ack, input logic [3:0] op,
                                 input logic [2:0] st, input logic [16:0] o);
        cyc_t e;
        e.ack = ack; e.op = op; e.st = st; e.outs = o;
        return e;
    endfunction

    // Expected trace of one instruction: fetch waits, fetch, decode, then class-specific phases.
    task automatic push_instr(input logic [3:0] op, input int waits);
        logic imm;
        logic [1:0] b;
        for (int w = 0; w < waits; w++)
            q.push_back(ent(1'b0, 4'($urandom), 3'd1, mk(1,0,0,0,0,0,2'b01,4'd0,2'b00,0,0,0)));
        q.push_back(ent(1'b1, 4'($urandom), 3'd1, mk(1,1,1,0,0,0,2'b01,4'd0,2'b00,0,0,0)));
        if (op >= 4'd13) begin
            q.push_back(ent(1'($urandom), op, 3'd2, mk(0,0,0,0,0,0,2'b00,4'd0,2'b00,0,1,1)));
        end else begin
            q.push_back(ent(1'($urandom), op, 3'd2, mk(0,0,0,0,0,0,2'b00,4'd0,2'b00,0,0,0)));
            if (op == 4'd11) begin
                q.push_back(ent(1'($urandom), 4'($urandom), 3'd5,
                                mk(0,0,1,0,0,0,2'b00,4'd0,2'b10,0,0,1)));
            end else if (op == 4'd12) begin
                q.push_back(ent(1'($urandom), 4'($urandom), 3'd6,
                                mk(0,0,0,1,0,1,2'b00,4'd12,2'b01,0,0,1)));
            end else begin
                imm = (op == 4'd2) || (op >= 4'd6);
                b   = imm ? 2'b10 : 2'b00;
                q.push_back(ent(1'($urandom), 4'($urandom), 3'd3,
                                mk(0,0,0,0,0,1,b,op,2'b00,imm,0,0)));
                q.push_back(ent(1'($urandom), 4'($urandom), 3'd4,
                                mk(0,0,0,0,1,1,b,op,2'b00,imm,0,1)));
            end
        end
    endtask

    // Called just after a rising edge; drains the expected trace one cycle at a time.
    task automatic run_queue();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_ack = e.ack;
            opcode  = e.op;
            @(negedge clk);
            chk("outs", 32'(dut_outs()), 32'(e.outs));
            chk("estado", 32'(estado), 32'(e.st));
`ifdef CONT_CICLOS_EN
            chk("ciclos", 32'(ciclos), 32'(m_ciclos));
            chk("instrucoes", 32'(instrucoes), 32'(m_instr));
`endif
            if (e.st != 3'd0) m_ciclos++;
            if (e.outs[0]) m_instr++;
            cycle++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; opcode = 4'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", 32'(dut_outs()), 32'd0);
            chk("rst_estado", 32'(estado), 32'd0);
            cycle++;
        end
        @(posedge clk);
        #1 rst = 1'b0;

        q.push_back(ent(1'b1, 4'd0, 3'd0, 17'd0));
        push_instr(4'd1, 0);
        push_instr(4'd6, 3);
        push_instr(4'd11, 0);
        push_instr(4'd12, 0);
        push_instr(4'd14, 0);
        for (int i = 0; i < 60; i++)
            push_instr(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        run_queue();

        // Reset asserted mid-fetch while memory is stalling.
        mem_ack = 1'b0;
        @(negedge clk);
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("fetch_estado", 32'(estado), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_estado", 32'(estado), 32'd0);
`ifdef CONT_CICLOS_EN
        chk("arst_ciclos", 32'(ciclos), 32'd0);
        chk("arst_instr", 32'(instrucoes), 32'd0);
`endif
        m_ciclos = 0;
        m_instr  = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        q.push_back(ent(1'b1, 4'd0, 3'd0, 17'd0));
        push_instr(4'd3, 1);
        push_instr(4'd10, 0);
        push_instr(4'd13, 2);
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
